// File: rtl/intr_ctrl.sv
// Always-on interrupt controller: sticky event status with per-bit clear, a periodic
// timer event, and an INT pin sequencer (polarity, level/pulse, cold hold-off, frame deferral).
//
// state  | meaning
// IDLE   | pin inactive, waiting for an enabled pending bit (and frame end if deferred)
// ACTIVE | pin asserted; level mode until pending drops, pulse mode for width+1 cycles
// COLD   | pin inactive hold-off of (cold_time+1) ms, counted from the first ms tick
module intr_ctrl #(
  parameter int NW = 12
) (
  input  logic          clk_32k,
  input  logic          rst_n,
  input  logic [NW-1:0] events_enable_int,
  input  logic [NW-1:0] event_clear,
  input  logic          rg_int_low_en,
  input  logic          rg_int_level_en,
  input  logic [10:0]   rg_int_width,
  input  logic [5:0]    rg_cold_time,
  input  logic          int_after_frame,
  input  logic          rg_timer_on,
  input  logic          rg_timer_mode,
  input  logic [8:0]    rg_timer_sel,
  input  logic          frame_on,
  input  logic          fifo_upov_flag,
  input  logic          fifo_downov_flag,
  input  logic          fifo_waterline_flag,
  input  logic          user_int_triger,
  input  logic          frame_done_flag,
  input  logic          data_satg_flag,
  input  logic          sample_err_flag,
  input  logic          cap_cancel_done_flag,
  input  logic          ldo_ov_flag,
  input  logic          opst_exc_flag,
  output logic [NW-1:0] events,
  output logic          int_out
);

  localparam logic [5:0]  MS_LAST    = 6'd32;
  localparam logic [12:0] TICK_LAST  = 13'd6553;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COLD   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [NW-1:0] src;
  logic          pending;
  logic          ms_tick;
  logic [5:0]    ms_cnt;
  logic          tmr_tick;
  logic          timer_expire;
  logic          timer_done;
  logic [12:0]   sub_cnt;
  logic [8:0]    per_cnt;
  logic [10:0]   pw_cnt;
  logic [6:0]    cold_cnt;

  always_comb begin
    src = '0;
    src[10:0] = {timer_expire, opst_exc_flag, ldo_ov_flag, cap_cancel_done_flag,
                 sample_err_flag, data_satg_flag, frame_done_flag, user_int_triger,
                 fifo_waterline_flag, fifo_downov_flag, fifo_upov_flag};
  end

  // set has priority over clear; unused upper bits can never set
  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) events <= '0;
    else        events <= (events & ~event_clear) | src;
  end

  assign pending = |(events & events_enable_int);

  assign ms_tick = (ms_cnt == MS_LAST);

  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n)       ms_cnt <= '0;
    else if (ms_tick) ms_cnt <= '0;
    else              ms_cnt <= ms_cnt + 6'd1;
  end

  assign tmr_tick     = (sub_cnt == TICK_LAST);
  assign timer_expire = rg_timer_on && !timer_done && tmr_tick && (per_cnt >= rg_timer_sel);

  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt    <= '0;
      per_cnt    <= '0;
      timer_done <= 1'b0;
    end else if (!rg_timer_on) begin
      sub_cnt    <= '0;
      per_cnt    <= '0;
      timer_done <= 1'b0;
    end else if (!timer_done) begin
      if (tmr_tick) begin
        sub_cnt <= '0;
        if (per_cnt >= rg_timer_sel) begin
          per_cnt    <= '0;
          timer_done <= !rg_timer_mode;
        end else begin
          per_cnt <= per_cnt + 9'd1;
        end
      end else begin
        sub_cnt <= sub_cnt + 13'd1;
      end
    end
  end

  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (pending && (!int_after_frame || !frame_on)) state_nxt = ACTIVE;
      ACTIVE:
        if (rg_int_level_en ? !pending : (pw_cnt >= rg_int_width)) state_nxt = COLD;
      COLD:
        if (ms_tick && (cold_cnt >= ({1'b0, rg_cold_time} + 7'd1))) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // counters saturate so a mid-flight register change still terminates via >=
  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) begin
      pw_cnt   <= '0;
      cold_cnt <= '0;
    end else begin
      if (state == ACTIVE && state_nxt == ACTIVE) begin
        if (pw_cnt != 11'h7ff) pw_cnt <= pw_cnt + 11'd1;
      end else begin
        pw_cnt <= '0;
      end
      if (state != COLD)                        cold_cnt <= '0;
      else if (ms_tick && cold_cnt != 7'h7f)    cold_cnt <= cold_cnt + 7'd1;
    end
  end

  assign int_out = (state == ACTIVE) ^ rg_int_low_en;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: status table vectors, directed pin/timer sequences and a
// randomized run checked every cycle against a timestamp-based reference model.
module tb_intr_ctrl;

  logic        clk_32k = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] events_enable_int = '0;
  logic [11:0] event_clear = '0;
  logic        rg_int_low_en = 1'b0;
  logic        rg_int_level_en = 1'b1;
  logic [10:0] rg_int_width = '0;
  logic [5:0]  rg_cold_time = '0;
  logic        int_after_frame = 1'b0;
  logic        rg_timer_on = 1'b0;
  logic        rg_timer_mode = 1'b0;
  logic [8:0]  rg_timer_sel = '0;
  logic        frame_on = 1'b0;
  logic [9:0]  flags = '0;
  logic [11:0] events;
  logic        int_out;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_on = 1'b0;

  intr_ctrl #(.NW(12)) dut (
    .clk_32k(clk_32k), .rst_n(rst_n),
    .events_enable_int(events_enable_int), .event_clear(event_clear),
    .rg_int_low_en(rg_int_low_en), .rg_int_level_en(rg_int_level_en),
    .rg_int_width(rg_int_width), .rg_cold_time(rg_cold_time),
    .int_after_frame(int_after_frame), .rg_timer_on(rg_timer_on),
    .rg_timer_mode(rg_timer_mode), .rg_timer_sel(rg_timer_sel), .frame_on(frame_on),
    .fifo_upov_flag(flags[0]), .fifo_downov_flag(flags[1]), .fifo_waterline_flag(flags[2]),
    .user_int_triger(flags[3]), .frame_done_flag(flags[4]), .data_satg_flag(flags[5]),
    .sample_err_flag(flags[6]), .cap_cancel_done_flag(flags[7]), .ldo_ov_flag(flags[8]),
    .opst_exc_flag(flags[9]),
    .events(events), .int_out(int_out)
  );

  always #5 clk_32k = ~clk_32k;

  // Reference model: edge index n since reset release; ms ticks fall on multiples
  // of 33, pulse/cold exits are computed from entry timestamps.
  int unsigned n = 0;
  int          m_phase = 0;
  int unsigned m_start = 0;
  int unsigned m_cold = 0;
  int unsigned t_el = 0;
  int unsigned t_per;
  logic [11:0] m_events = '0;
  logic [11:0] m_src;
  logic        m_pend;
  logic        m_exp;

  always @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_phase = 0; m_events = '0; t_el = 0;
    end else begin
      n = n + 1;
      m_pend = |(m_events & events_enable_int);
      if (rg_timer_on) t_el = t_el + 1;
      else             t_el = 0;
      t_per = 6554 * (int'(rg_timer_sel) + 1);
      m_exp = rg_timer_on && (t_el % t_per == 0) && (rg_timer_mode || t_el == t_per);
      m_src = {1'b0, m_exp, flags};
      case (m_phase)
        0: if (m_pend && (!int_after_frame || !frame_on)) begin m_phase = 1; m_start = n; end
        1: if (rg_int_level_en ? !m_pend : (n - m_start > int'(rg_int_width))) begin
             m_phase = 2; m_cold = n;
           end
        default:
          if (n % 33 == 0 && (n / 33 - m_cold / 33) >= int'(rg_cold_time) + 2) m_phase = 0;
      endcase
      m_events = (m_events & ~event_clear) | m_src;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    vec_cnt++;
    if (act < lo || act > hi) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  always @(negedge clk_32k) begin
    if (rst_n && chk_on) begin
      chk("model_events", 32'(events), 32'(m_events));
      chk("model_int_out", 32'(int_out), 32'((m_phase == 1) ^ rg_int_low_en));
    end
  end

  task automatic step();
    @(posedge clk_32k);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_32k);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_events", 32'(events), 32'h0);
    chk("rst_int_out", 32'(int_out), 32'(rg_int_low_en));
    repeat (2) @(posedge clk_32k);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_pin(input logic lvl, input int max, output int cnt);
    cnt = 0;
    while (int_out !== lvl) begin
      if (cnt >= max) begin cnt = -1; return; end
      step();
      cnt++;
    end
  endtask

  typedef struct {
    logic [9:0]  src;
    logic [11:0] clr;
    logic [11:0] exp_ev;
  } vec_t;

  vec_t tbl[8];
  int   c;
  bit   seen;

  initial begin
    tbl[0] = '{10'h008, 12'h000, 12'h008};
    tbl[1] = '{10'h001, 12'h008, 12'h001};
    tbl[2] = '{10'h002, 12'h002, 12'h003};
    tbl[3] = '{10'h000, 12'hfff, 12'h000};
    tbl[4] = '{10'h3ff, 12'h000, 12'h3ff};
    tbl[5] = '{10'h000, 12'h155, 12'h2aa};
    tbl[6] = '{10'h200, 12'h200, 12'h2aa};
    tbl[7] = '{10'h004, 12'hfff, 12'h004};

    // Reset state and clear-all with nothing pending
    do_reset();
    chk_on = 1'b1;
    event_clear = '1; step(); event_clear = '0;
    chk("s1_events", 32'(events), 32'h0);
    chk("s1_int_out", 32'(int_out), 32'h0);

    // Status set/clear rules, pin disabled
    foreach (tbl[i]) begin
      flags = tbl[i].src; event_clear = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_events", i), 32'(events), 32'(tbl[i].exp_ev));
      chk($sformatf("tbl%0d_int_out", i), 32'(int_out), 32'h0);
    end
    flags = '0; event_clear = '0;

    // Level mode, active high, cold hold-off
    rg_int_level_en = 1'b1; rg_cold_time = 6'h13; events_enable_int = '1;
    do_reset();
    flags[3] = 1'b1; step(); flags[3] = 1'b0;
    chk("s2_events", 32'(events), 32'h008);
    chk("s2_int_early", 32'(int_out), 32'h0);
    step();
    chk("s2_int_assert", 32'(int_out), 32'h1);
    repeat (10) step();
    chk("s2_int_hold", 32'(int_out), 32'h1);
    event_clear = '1; step(); event_clear = '0;
    chk("s2_cleared", 32'(events), 32'h0);
    chk("s2_int_lag", 32'(int_out), 32'h1);
    step();
    chk("s2_int_drop", 32'(int_out), 32'h0);
    repeat (3) step();
    flags[3] = 1'b1; step(); flags[3] = 1'b0;
    wait_pin(1'b1, 800, c);
    chk_rng("s2_cold_low", (c < 0) ? c : c + 4, 662, 694);

    // Pulse mode, 640-cycle pulses repeating while bit 3 stays set
    rg_int_level_en = 1'b0; rg_int_width = 11'h27f;
    do_reset();
    flags[3] = 1'b1; step(); flags[3] = 1'b0;
    wait_pin(1'b1, 5, c);    chk("s3_latency", 32'(c), 32'd1);
    wait_pin(1'b0, 3000, c); chk("s3_width1", 32'(c), 32'd640);
    wait_pin(1'b1, 2000, c); chk_rng("s3_cold_low", c, 662, 694);
    wait_pin(1'b0, 3000, c); chk("s3_width2", 32'(c), 32'd640);

    // Active-low pin, short pulse and minimum cold time
    rg_int_low_en = 1'b1; rg_int_width = 11'd9; rg_cold_time = 6'd0;
    do_reset();
    chk("s4_idle_high", 32'(int_out), 32'h1);
    flags[0] = 1'b1; step(); flags[0] = 1'b0;
    wait_pin(1'b0, 5, c);   chk("s4_latency", 32'(c), 32'd1);
    wait_pin(1'b1, 100, c); chk("s4_width", 32'(c), 32'd10);
    wait_pin(1'b0, 200, c); chk_rng("s4_cold", c, 35, 67);

    // Frame deferral
    rg_int_low_en = 1'b0; rg_int_level_en = 1'b1; rg_cold_time = 6'd2;
    int_after_frame = 1'b1; frame_on = 1'b1;
    do_reset();
    flags[5] = 1'b1; step(); flags[5] = 1'b0;
    chk("s5_events", 32'(events), 32'h020);
    seen = 1'b0;
    repeat (20) begin step(); if (int_out) seen = 1'b1; end
    chk("s5_deferred", 32'(seen), 32'h0);
    frame_on = 1'b0; step();
    chk("s5_release", 32'(int_out), 32'h1);
    frame_on = 1'b1; repeat (5) step();
    chk("s5_frame_in_active", 32'(int_out), 32'h1);
    int_after_frame = 1'b0; frame_on = 1'b0;

    // Periodic timer: auto reload then single shot
    events_enable_int = '0;
    do_reset();
    rg_timer_sel = 9'd0; rg_timer_mode = 1'b1; rg_timer_on = 1'b1;
    c = 0;
    do begin step(); c++; end while (!events[10] && c < 7000);
    chk("s6_auto_first", 32'(c), 32'd6554);
    event_clear[10] = 1'b1; step(); event_clear[10] = 1'b0;
    chk("s6_cleared", 32'(events[10]), 32'h0);
    c = 1;
    do begin step(); c++; end while (!events[10] && c < 7000);
    chk("s6_auto_period", 32'(c), 32'd6554);
    rg_timer_on = 1'b0; rg_timer_mode = 1'b0;
    event_clear[10] = 1'b1; step(); event_clear[10] = 1'b0;
    rg_timer_on = 1'b1;
    c = 0;
    do begin step(); c++; end while (!events[10] && c < 7000);
    chk("s6_single_first", 32'(c), 32'd6554);
    event_clear[10] = 1'b1; step(); event_clear[10] = 1'b0;
    seen = 1'b0;
    repeat (7000) begin step(); if (events[10]) seen = 1'b1; end
    chk("s6_single_once", 32'(seen), 32'h0);
    rg_timer_on = 1'b0;

    // Randomized traffic against the model
    rg_timer_mode = 1'b1; rg_timer_sel = 9'd0;
    do_reset();
    rg_timer_on = 1'b1;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      for (int b = 0; b < 10; b++) flags[b] = ($urandom_range(63) == 0);
      event_clear = ($urandom_range(15) == 0) ? 12'($urandom) : 12'h000;
      if ($urandom_range(31) == 0) frame_on = ~frame_on;
      if (cyc % 200 == 0) begin
        events_enable_int = 12'($urandom);
        rg_int_width      = 11'($urandom_range(15));
        rg_cold_time      = 6'($urandom_range(3));
        int_after_frame   = 1'($urandom);
      end
      if (cyc % 300 == 0) begin
        rg_int_level_en = 1'($urandom);
        rg_int_low_en   = 1'($urandom);
      end
      step();
    end

    // Async reset mid-operation
    flags = 10'h3ff;
    step();
    flags = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_events", 32'(events), 32'h0);
    chk("async_rst_int_out", 32'(int_out), 32'(rg_int_low_en));
    step();
    rst_n = 1'b1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller in the always-on 32 kHz domain.
- Latches ten hardware event flags plus an internal periodic-timer event into a sticky status register; bits are software-clearable.
- Drives a single INT pin from the enabled status bits.
- Pin behaviour is configurable: polarity, level or pulse mode, pulse width, cold (hold-off) time, and optional deferral until the current sensing frame ends.

Parameters:
NW, 12, number of event/status bits (bits 0..10 used, bits 11..NW-1 tie to 0)

Ports:
clk_32k  in  1  32.768 kHz clock
rst_n  in  1  asynchronous active-low reset
events_enable_int  in  NW  per-bit enable of status bit onto INT pin
event_clear  in  NW  per-bit clear of status (level, sampled each cycle)
rg_int_low_en  in  1  0: INT active high; 1: INT active low
rg_int_level_en  in  1  0: pulse mode; 1: level mode
rg_int_width  in  11  pulse width = value+1 clk_32k cycles (1..2048)
rg_cold_time  in  6  hold-off = (value+1) ms (1..64)
int_after_frame  in  1  1: defer INT assertion while frame_on=1
rg_timer_on  in  1  periodic timer enable
rg_timer_mode  in  1  0: single-shot; 1: auto-reload
rg_timer_sel  in  9  timer period = (value+1)*0.2 s
frame_on  in  1  sensing frame in progress
fifo_upov_flag, fifo_downov_flag, fifo_waterline_flag, user_int_triger, frame_done_flag, data_satg_flag, sample_err_flag, cap_cancel_done_flag, ldo_ov_flag, opst_exc_flag  in  1 each  event sources
events  out  NW  sticky status, read-only
int_out  out  1  INT pin

Behaviour:
- Reset: events=0, all counters=0, FSM=IDLE, int_out=rg_int_low_en (inactive level).
- Bit map: 0 fifo_upov, 1 fifo_downov, 2 fifo_waterline, 3 user_int_triger, 4 frame_done, 5 data_satg, 6 sample_err, 7 cap_cancel_done, 8 ldo_ov, 9 opst_exc, 10 timer_expire, 11+ constant 0.
- Status set/clear:
  - Source high at a clock edge sets its bit on that edge; events shows it one cycle after the source is sampled.
  - event_clear bit clears on the next edge.
  - Set and clear in the same cycle: set wins.
- pending = |(events & events_enable_int).
- ms tick: free-running 0..32 counter, i.e. 1 ms = 33 cycles.
- Timer:
  - 0.2 s tick = 6554 cycles; tick count runs to rg_timer_sel+1, then pulses timer_expire for one cycle.
  - Auto mode restarts the count; single mode stops until rg_timer_on is cleared and set again.
  - rg_timer_on=0 holds all timer counters at 0.
- FSM states:
  - IDLE: wait for an assertion request. Request = pending, gated by (!int_after_frame | !frame_on). Go to ACTIVE.
  - ACTIVE, level mode: stay while pending=1. Leave when pending=0 (all enabled bits cleared).
  - ACTIVE, pulse mode: hold for rg_int_width+1 cycles, then leave regardless of pending.
  - On leaving ACTIVE, go to COLD.
  - COLD: INT inactive for (rg_cold_time+1) ms, counted from the first ms tick after entry, then return to IDLE. Pending still set in pulse mode produces a new pulse after COLD.
- int_out: registered, = (state==ACTIVE) XOR rg_int_low_en. Asserts one cycle after events shows the bit.
- Register changes mid-pulse take effect at the next comparison; no shadowing.
- Deferral: if frame_on rises while in ACTIVE, the pin is not affected.
- Async reset mid-operation immediately returns all state to reset values.

Test Plan:
1. Reset, all sources 0, event_clear pulse of all ones → events=0, int_out=0 throughout.
2. Level mode, active high, all enabled; one-cycle user_int_triger → events=12'h008 next cycle, int_out=1 one cycle later and held; event_clear=all ones for one cycle → int_out=0; no reassertion during the 20 ms cold time (rg_cold_time=6'h13).
3. Pulse mode, rg_int_width=11'h27f → int_out high exactly 640 cycles; stays low for (6'h13+1)=20 ms (660 cycles); then pulses again because bit 3 is still set.
4. rg_int_low_en=1 → idle int_out=1, active int_out=0; same timing as scenarios 2/3.
5. int_after_frame=1 and frame_on=1 while data_satg_flag pulses → events[5]=1 but int_out inactive; frame_on falls → int_out asserts on the next cycle.
6. rg_timer_on=1, rg_timer_sel=0, auto mode → events[10] sets every 6554 cycles (re-set after each clear); single mode sets it only once.
